counter_arbiter: RTL and testbench

Shares a single loadable up-counter between `NUM_REQ` requesters, each asking for a timed interval of `len + 1` count cycles. It arbitrates among requesters, loads and runs the shared count register, and signals completion to the granted requester. It sits between the control FSMs that need delays and the memory/arithmetic counter datapath, so only one counter instance is needed per cluster.

---
 rtl/counter_arbiter_if.sv | 26 ++
 rtl/counter_arbiter.sv | 149 ++++++++++++++
 tb/tb_counter_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if -- request/grant bundle between the requesters and the
// shared interval counter.
//
//   req   : level request, one bit per requester
//   len   : packed terminal values, requester k at [k*BUS_WIDTH +: BUS_WIDTH]
//   grant : one-hot owner of the counter, zero when idle
//   done  : one-cycle one-hot completion pulse to the owner
//   busy  : counter is allocated (not idle)
//   cnt   : current count register value
//
// master : requester side (drives req/len)
// slave  : counter_arbiter side (drives grant/done/busy/cnt)
interface counter_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BUS_WIDTH-1:0] len;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic                         busy;
    logic [BUS_WIDTH-1:0]         cnt;

    modport master (output req, len, input grant, done, busy, cnt);
    modport slave  (input req, len, output grant, done, busy, cnt);
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter -- one loadable up-counter shared by NUM_REQ requesters.
// The winner's length is latched at grant, the counter runs 0..len_q, and
// a one-cycle done pulse is returned to the owner before the counter is
// released. At least one idle cycle separates consecutive grants.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : counter_arbiter_if.slave (req/len in, grant/done/busy/cnt out)
//
// Build option:
//   COUNTER_ARB_RR_EN defined   -> round-robin arbitration, search starts
//                                  after the last granted index
//   COUNTER_ARB_RR_EN undefined -> fixed priority, lowest index wins
module counter_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    counter_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q,  done_d;
    logic [BUS_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [BUS_WIDTH-1:0]   len_q,   len_d;

    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;

`ifdef COUNTER_ARB_RR_EN
    logic [IDX_W-1:0]       ptr_q, ptr_d;   // first index searched
    logic [IDX_W-1:0]       idx_q, idx_d;   // current owner index
    int                     cand;
`endif

    // Winner selection over the request bits seen in this cycle.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
`ifdef COUNTER_ARB_RR_EN
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Rotate the search origin without a modulo operator.
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // path through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef COUNTER_ARB_RR_EN
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    len_d   = bus.len[int'(win_idx)*BUS_WIDTH +: BUS_WIDTH];
                    grant_d = NUM_REQ'(1) << win_idx;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef COUNTER_ARB_RR_EN
                    idx_d   = win_idx;
`endif
                end
            end
            S_RUN: begin
                // Stop on equality so the count never wraps, even at all-ones.
                if (cnt_q == len_q) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                done_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
`ifdef COUNTER_ARB_RR_EN
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef COUNTER_ARB_RR_EN
            ptr_q   <= '0;
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef COUNTER_ARB_RR_EN
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.cnt   = cnt_q;
    assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter -- scoreboard bench for counter_arbiter.
// The stimulus side predicts each grant (owner, latched length) with a
// plain arbitration model and queues it; the monitor pops an entry when a
// grant appears and checks grant, cnt, done and the window length.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int idx;
        int len;
        bit abort;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   model_ptr;
    exp_t sb_q[$];

    counter_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) ar ();

    counter_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule from the spec, with a plain rotating start index.
    function automatic int model_pick(input logic [N-1:0] mask);
        int c;
`ifdef COUNTER_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            c = (model_ptr + k) % N;
            if (mask[c]) begin
                model_ptr = (c + 1) % N;
                return c;
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            if (mask[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Called at posedge+1; returns at posedge+1 of an idle cycle.
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (ar.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("idle_timeout", 32'(ar.busy), 32'd0);
    endtask

    task automatic arbitrate(input logic [N-1:0] mask, input logic [N*W-1:0] lens,
                             input bit drop, input bit change_len, input bit abort);
        exp_t e;
        wait_idle();
        ar.req  = mask;
        ar.len  = lens;
        e.idx   = model_pick(mask);
        e.len   = int'(lens[e.idx*W +: W]);
        e.abort = abort;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (drop)       ar.req = '0;
        if (change_len) ar.len = ~lens;
    endtask

    // Monitor: one pass per cycle, away from the active edge.
    int   cyc;
    bit   active;
    exp_t cur;

    initial begin
        active = 1'b0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (active && !cur.abort) check("reset_during_expected_interval", 32'(cyc), 32'(cur.len + 2));
                active = 1'b0;
            end else if (ar.grant !== '0) begin
                if (!active) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_grant", 32'(ar.grant), 32'd0);
                    end else begin
                        cur    = sb_q.pop_front();
                        active = 1'b1;
                        cyc    = 0;
                    end
                end
                if (active) begin
                    check("grant", 32'(ar.grant), 32'(1) << cur.idx);
                    check("busy", 32'(ar.busy), 32'd1);
                    check("cnt", 32'(ar.cnt), (cyc < cur.len) ? 32'(cyc) : 32'(cur.len));
                    check("done", 32'(ar.done), (cyc == cur.len + 1) ? (32'(1) << cur.idx) : 32'd0);
                    cyc++;
                end
            end else begin
                if (active) begin
                    check("grant_window", 32'(cyc), 32'(cur.len + 2));
                    active = 1'b0;
                end
                check("idle_busy", 32'(ar.busy), 32'd0);
                check("idle_cnt", 32'(ar.cnt), 32'd0);
                check("idle_done", 32'(ar.done), 32'd0);
            end
        end
    end

    initial begin
        logic [N*W-1:0] lens;
        logic [N-1:0]   mask;
        n_checks  = 0;
        n_errors  = 0;
        model_ptr = 0;

        // Reset held with every requester asserted: reset must dominate.
        rst_n  = 1'b0;
        ar.req = '1;
        ar.len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(ar.grant), 32'd0);
        check("rst_done", 32'(ar.done), 32'd0);
        check("rst_busy", 32'(ar.busy), 32'd0);
        check("rst_cnt", 32'(ar.cnt), 32'd0);
        rst_n  = 1'b1;
        ar.req = '0;
        @(posedge clk);
        #1;

        // Single request, len 3 -> 5 grant cycles.
        lens = '0; lens[0*W +: W] = 8'd3;
        arbitrate(4'b0001, lens, 1'b1, 1'b0, 1'b0);
        // Zero length -> 2 grant cycles.
        lens = '0; lens[2*W +: W] = 8'd0;
        arbitrate(4'b0100, lens, 1'b1, 1'b0, 1'b0);
        // Maximum length, no wrap, 257 grant cycles.
        lens = '0; lens[1*W +: W] = 8'd255;
        arbitrate(4'b0010, lens, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a len 5 interval at cnt = 2.
        wait_idle();
        lens = '0; lens[0*W +: W] = 8'd5;
        arbitrate(4'b0001, lens, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_cnt", 32'(ar.cnt), 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_grant", 32'(ar.grant), 32'd0);
        check("mid_rst_busy", 32'(ar.busy), 32'd0);
        check("mid_rst_cnt", 32'(ar.cnt), 32'd0);
        check("mid_rst_done", 32'(ar.done), 32'd0);
        rst_n     = 1'b1;
        model_ptr = 0;
        @(posedge clk); #1;

        // Contention with all requests held, every len = 1.
        lens = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int i = 0; i < 5; i++) arbitrate(4'b1111, lens, (i == 4), 1'b0, 1'b0);

        // Request dropped and length changed after grant.
        lens = '0; lens[3*W +: W] = 8'd7;
        arbitrate(4'b1000, lens, 1'b1, 1'b1, 1'b0);

        // Randomised episodes.
        for (int i = 0; i < 40; i++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) lens[k*W +: W] = W'($urandom_range(0, 12));
            arbitrate(mask, lens, (i == 39) || ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 1) == 1), 1'b0);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
